hazard_controller: RTL and testbench
====================================

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in MEM_WAIT before error.
REQ-002 Parameter CNT_W, default 16: width of stall-cycle counter.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 ID_Rs1_i, ID_Rs2_i  in  5 each  source registers of instruction in ID.
REQ-006 ID_UseRs2_i  in  1  ID instruction reads rs2.
REQ-007 EX_Rd_i  in  5  destination register of instruction in EX.
REQ-008 EX_MemRead_i  in  1  EX instruction is a load.
REQ-009 Branch_Taken_i  in  1  branch resolved taken in ID this cycle.
REQ-010 Mem_Req_i  in  1  MEM stage issuing a data access this cycle.
REQ-011 Mem_Ack_i  in  1  data memory completes the access this cycle.
REQ-012 PCWrite_o  out  1  PC update enable.
REQ-013 IFID_Write_o  out  1  IF/ID register write enable.
REQ-014 IDEX_NoOp_o  out  1  insert bubble into ID/EX (zero control).
REQ-015 IFID_Flush_o  out  1  clear IF/ID (taken-branch squash).
REQ-016 Pipe_Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-017 State_o  out  2  current FSM state (RUN=0, MEM_WAIT=1, ERR=2).
REQ-018 StallCnt_o  out  CNT_W  cycles with PCWrite_o=0, saturating.
REQ-019 Err_o  out  1  sticky memory-timeout flag.

Function
REQ-020 FSM states RUN, MEM_WAIT, ERR; encoding 3 unused, SHALL go to RUN next cycle.
REQ-021 freeze_c = (State==RUN & Mem_Req_i & ~Mem_Ack_i) | (State==MEM_WAIT & ~Mem_Ack_i); Pipe_Freeze_o = freeze_c, combinational.
REQ-022 lu_c = EX_MemRead_i & EX_Rd_i!=0 & (EX_Rd_i==ID_Rs1_i | (ID_UseRs2_i & EX_Rd_i==ID_Rs2_i)).
REQ-023 Priority freeze > load-use > branch: freeze_c -> PCWrite_o=0, IFID_Write_o=0, IDEX_NoOp_o=0, IFID_Flush_o=0.
REQ-024 Else lu_c -> PCWrite_o=0, IFID_Write_o=0, IDEX_NoOp_o=1, IFID_Flush_o=0 (same cycle, zero latency).
REQ-025 Else Branch_Taken_i -> PCWrite_o=1, IFID_Write_o=1, IFID_Flush_o=1, IDEX_NoOp_o=0.
REQ-026 Else PCWrite_o=1, IFID_Write_o=1, IDEX_NoOp_o=0, IFID_Flush_o=0.
REQ-027 RUN -> MEM_WAIT when Mem_Req_i=1 and Mem_Ack_i=0; request with same-cycle ack stays RUN, no freeze.
REQ-028 MEM_WAIT -> RUN when Mem_Ack_i=1; freeze deasserts in the ack cycle itself.
REQ-029 Internal wait counter cleared on RUN->MEM_WAIT, +1 per MEM_WAIT cycle without ack.
REQ-030 MEM_WAIT with Mem_Ack_i=0 and wait counter==TIMEOUT-1 -> ERR; at most TIMEOUT cycles in MEM_WAIT.
REQ-031 ERR lasts exactly one cycle, freeze_c=0 there, sets Err_o=1, then RUN; Err_o held until reset.
REQ-032 Ack arriving on the timeout cycle wins: MEM_WAIT -> RUN, no error.
REQ-033 StallCnt_o +1 each cycle PCWrite_o=0; saturates at 2^CNT_W-1, never wraps.
REQ-034 Mem_Ack_i while in RUN without Mem_Req_i ignored.

Reset
REQ-035 rst_i=0 immediately: State=RUN, wait counter=0, StallCnt_o=0, Err_o=0; outputs then follow REQ-021..026 from live inputs.
REQ-036 Reset asserted mid-MEM_WAIT aborts wait; after release, FSM in RUN, no freeze unless new request.

Verification
REQ-037 EX load x5, ID add rs1=x5 -> one cycle PCWrite_o=0, IFID_Write_o=0, IDEX_NoOp_o=1; StallCnt_o 0->1.
REQ-038 EX load x0, ID rs1=x0; and EX load x6, ID rs2=x6 with ID_UseRs2_i=0 -> no stall either case.
REQ-039 Mem_Req_i=1, Mem_Ack_i after 4 cycles -> State_o=1 for 4 cycles, Pipe_Freeze_o=1 for 4 cycles (0 in ack cycle), StallCnt_o +4.
REQ-040 Freeze active with Branch_Taken_i=1 and lu_c=1 -> IFID_Flush_o=0, IDEX_NoOp_o=0; after ack, branch flush then applied.
REQ-041 TIMEOUT=8, no ack -> 8 cycles MEM_WAIT, 1 cycle ERR, Err_o=1 sticky; ack at 8th cycle instead -> RUN, Err_o=0.
REQ-042 CNT_W=4, 20 stall cycles -> StallCnt_o holds 15; rst_i=0 mid-MEM_WAIT -> State_o=0, StallCnt_o=0 asynchronously.

Source files
------------

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch squash and
// data-memory wait freeze with a timeout that raises a sticky error flag.
module hazard_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic             ID_UseRs2_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             EX_MemRead_i,
  input  logic             Branch_Taken_i,
  input  logic             Mem_Req_i,
  input  logic             Mem_Ack_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IDEX_NoOp_o,
  output logic             IFID_Flush_o,
  output logic             Pipe_Freeze_o,
  output logic [1:0]       State_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic             Err_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  // The wait counter only has to reach TIMEOUT-1 before the error fires.
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              err;
  logic              freeze_c;
  logic              lu_c;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_noop;
  logic              ifid_flush;

  // Control outputs are combinational so a stall takes effect in the same cycle.
  always_comb begin
    freeze_c = ((state == RUN) && Mem_Req_i && !Mem_Ack_i) ||
               ((state == MEM_WAIT) && !Mem_Ack_i);
    lu_c     = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
               ((EX_Rd_i == ID_Rs1_i) || (ID_UseRs2_i && (EX_Rd_i == ID_Rs2_i)));
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    idex_noop  = 1'b0;
    ifid_flush = 1'b0;
    if (freeze_c) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (lu_c) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_noop  = 1'b1;
    end else if (Branch_Taken_i) begin
      ifid_flush = 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (!pc_write && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_ONE;
      case (state)
        RUN: begin
          if (Mem_Req_i && !Mem_Ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          // An ack on the final allowed cycle still completes normally.
          if (Mem_Ack_i) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        ERR:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign PCWrite_o     = pc_write;
  assign IFID_Write_o  = ifid_write;
  assign IDEX_NoOp_o   = idex_noop;
  assign IFID_Flush_o  = ifid_flush;
  assign Pipe_Freeze_o = freeze_c;
  assign State_o       = state;
  assign StallCnt_o    = stall_cnt;
  assign Err_o         = err;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (TIMEOUT=8, CNT_W=4): directed
// cycles push hand-computed expectations, a negedge monitor pops and checks.
module tb_hazard_controller;

  localparam int CNT_W = 4;

  localparam logic [3:0] NORM = 4'b1100;  // {pc_write, ifid_write, noop, flush}
  localparam logic [3:0] LU   = 4'b0010;
  localparam logic [3:0] BR   = 4'b1101;
  localparam logic [3:0] FZ   = 4'b0000;

  typedef struct packed {
    logic [3:0] ctl;
    logic       fz;
    logic [1:0] st;
    logic [3:0] sc;
    logic       er;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic [4:0]       ID_Rs1_i = 5'd1;
  logic [4:0]       ID_Rs2_i = 5'd2;
  logic             ID_UseRs2_i = 1'b1;
  logic [4:0]       EX_Rd_i = 5'd3;
  logic             EX_MemRead_i = 1'b0;
  logic             Branch_Taken_i = 1'b0;
  logic             Mem_Req_i = 1'b0;
  logic             Mem_Ack_i = 1'b0;
  logic             PCWrite_o;
  logic             IFID_Write_o;
  logic             IDEX_NoOp_o;
  logic             IFID_Flush_o;
  logic             Pipe_Freeze_o;
  logic [1:0]       State_o;
  logic [CNT_W-1:0] StallCnt_o;
  logic             Err_o;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t sb[$];

  hazard_controller #(.TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_Rs1_i(ID_Rs1_i), .ID_Rs2_i(ID_Rs2_i), .ID_UseRs2_i(ID_UseRs2_i),
    .EX_Rd_i(EX_Rd_i), .EX_MemRead_i(EX_MemRead_i),
    .Branch_Taken_i(Branch_Taken_i), .Mem_Req_i(Mem_Req_i), .Mem_Ack_i(Mem_Ack_i),
    .PCWrite_o(PCWrite_o), .IFID_Write_o(IFID_Write_o), .IDEX_NoOp_o(IDEX_NoOp_o),
    .IFID_Flush_o(IFID_Flush_o), .Pipe_Freeze_o(Pipe_Freeze_o), .State_o(State_o),
    .StallCnt_o(StallCnt_o), .Err_o(Err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int cyc, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic mr,
                     input logic br, input logic rq, input logic ak,
                     input logic [3:0] ctl, input logic fz, input logic [1:0] st,
                     input logic [3:0] sc, input logic er);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = r;  ID_Rs1_i = rs1;  ID_Rs2_i = rs2;  ID_UseRs2_i = u2;
    EX_Rd_i = rd;  EX_MemRead_i = mr;  Branch_Taken_i = br;
    Mem_Req_i = rq;  Mem_Ack_i = ak;
    e = '{ctl: ctl, fz: fz, st: st, sc: sc, er: er};
    sb.push_back(e);
  endtask

  task automatic idle(input logic r, input logic [1:0] st, input logic [3:0] sc,
                      input logic er);
    cyc(r, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, NORM, 1'b0, st, sc, er);
  endtask

  task automatic mreq(input logic ak, input logic [3:0] ctl, input logic fz,
                      input logic [1:0] st, input logic [3:0] sc, input logic er);
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, ak, ctl, fz, st, sc, er);
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  int mon_cyc = 0;
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      mon_cyc++;
      check("pc_write",   mon_cyc, 16'(PCWrite_o),    16'(e.ctl[3]));
      check("ifid_write", mon_cyc, 16'(IFID_Write_o), 16'(e.ctl[2]));
      check("idex_noop",  mon_cyc, 16'(IDEX_NoOp_o),  16'(e.ctl[1]));
      check("ifid_flush", mon_cyc, 16'(IFID_Flush_o), 16'(e.ctl[0]));
      check("freeze",     mon_cyc, 16'(Pipe_Freeze_o), 16'(e.fz));
      check("state",      mon_cyc, 16'(State_o),      16'(e.st));
      check("stall_cnt",  mon_cyc, 16'(StallCnt_o),   16'(e.sc));
      check("err",        mon_cyc, 16'(Err_o),        16'(e.er));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then release.
    idle(1'b0, 2'd0, 4'd0, 1'b0);
    idle(1'b1, 2'd0, 4'd0, 1'b0);
    // Load-use on rs1: one stall cycle, counter 0 -> 1.
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0, 2'd0, 4'd0, 1'b0);
    idle(1'b1, 2'd0, 4'd1, 1'b0);
    // Load to x0 and unused rs2 match: no stall; used rs2 match: stall.
    cyc(1'b1, 5'd0, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 2'd0, 4'd1, 1'b0);
    cyc(1'b1, 5'd1, 5'd6, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, NORM, 1'b0, 2'd0, 4'd1, 1'b0);
    cyc(1'b1, 5'd1, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0, 2'd0, 4'd1, 1'b0);
    idle(1'b1, 2'd0, 4'd2, 1'b0);
    // Taken branch alone flushes IF/ID.
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, BR, 1'b0, 2'd0, 4'd2, 1'b0);
    // Memory wait: request, 3 more wait cycles, ack on the 4th MEM_WAIT cycle.
    mreq(1'b0, FZ, 1'b1, 2'd0, 4'd2, 1'b0);
    mreq(1'b0, FZ, 1'b1, 2'd1, 4'd3, 1'b0);
    mreq(1'b0, FZ, 1'b1, 2'd1, 4'd4, 1'b0);
    mreq(1'b0, FZ, 1'b1, 2'd1, 4'd5, 1'b0);
    mreq(1'b1, NORM, 1'b0, 2'd1, 4'd6, 1'b0);
    idle(1'b1, 2'd0, 4'd6, 1'b0);
    // Request with same-cycle ack stays in RUN; stray ack ignored.
    mreq(1'b1, NORM, 1'b0, 2'd0, 4'd6, 1'b0);
    idle(1'b1, 2'd0, 4'd6, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, NORM, 1'b0, 2'd0, 4'd6, 1'b0);
    idle(1'b1, 2'd0, 4'd6, 1'b0);
    // Freeze outranks load-use and branch; branch flush lands in the ack cycle.
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, FZ, 1'b1, 2'd0, 4'd6, 1'b0);
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, FZ, 1'b1, 2'd1, 4'd7, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, BR, 1'b0, 2'd1, 4'd8, 1'b0);
    idle(1'b1, 2'd0, 4'd8, 1'b0);
    // Timeout: 8 MEM_WAIT cycles, counter saturates at 15, one ERR cycle.
    mreq(1'b0, FZ, 1'b1, 2'd0, 4'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [3:0] sc;
      sc = (i < 7) ? 4'(9 + i) : 4'd15;
      mreq(1'b0, FZ, 1'b1, 2'd1, sc, 1'b0);
    end
    idle(1'b1, 2'd2, 4'd15, 1'b1);
    idle(1'b1, 2'd0, 4'd15, 1'b1);
    cyc(1'b1, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0, 2'd0, 4'd15, 1'b1);
    idle(1'b1, 2'd0, 4'd15, 1'b1);
    // Reset mid-MEM_WAIT takes effect before the next edge; outputs follow live inputs.
    mreq(1'b0, FZ, 1'b1, 2'd0, 4'd15, 1'b1);
    mreq(1'b0, FZ, 1'b1, 2'd1, 4'd15, 1'b1);
    cyc(1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, 1'b0, 2'd0, 4'd0, 1'b0);
    idle(1'b1, 2'd0, 4'd0, 1'b0);
    // Ack on the 8th MEM_WAIT cycle wins over the timeout.
    mreq(1'b0, FZ, 1'b1, 2'd0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      mreq(1'b0, FZ, 1'b1, 2'd1, 4'(1 + i), 1'b0);
    end
    mreq(1'b1, NORM, 1'b0, 2'd1, 4'd8, 1'b0);
    idle(1'b1, 2'd0, 4'd8, 1'b0);
    idle(1'b1, 2'd0, 4'd8, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk_i);
    check("scoreboard_drained", mon_cyc, 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
